// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot pixel engine.
// Holds the FSM state encoding and default fixed-point parameters.
// Fixed-point format is 2.(WIDTH-2) two's complement.
package mandelbrot_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ITER_WIDTH = 6;

  // 1.0 in the default 2.(WIDTH-2) format
  localparam int FX_ONE = 1 << (DEF_WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mandelbrot_pixel_engine_if.sv
// Request/result handshake bundle for the pixel engine.
// master = producer of requests and consumer of results; slave = engine.
// Widths follow the engine's WIDTH / ITER_WIDTH parameters.
interface mandelbrot_pixel_engine_if #(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 6
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_cr;
  logic [WIDTH-1:0]      in_ci;
  logic [ITER_WIDTH-1:0] max_iter;
  logic                  out_valid;
  logic                  out_ready;
  logic [ITER_WIDTH-1:0] out_iter;
  logic                  out_escaped;

  modport master (
    output in_valid, in_cr, in_ci, max_iter, out_ready,
    input  in_ready, out_valid, out_iter, out_escaped
  );

  modport slave (
    input  in_valid, in_cr, in_ci, max_iter, out_ready,
    output in_ready, out_valid, out_iter, out_escaped
  );

endinterface

// File: rtl/mandelbrot_alu.sv
// One combinational Mandelbrot step: z' = z^2 + c, plus escape flags.
// Latency: zero cycles (purely combinational).
// No backpressure; size is judged on the current z, overflow on z'.
module mandelbrot_alu
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] zr,
  input  logic [WIDTH-1:0] zi,
  input  logic [WIDTH-1:0] cr,
  input  logic [WIDTH-1:0] ci,
  output logic [WIDTH-1:0] out_zr,
  output logic [WIDTH-1:0] out_zi,
  output logic             size,
  output logic             overflow
);

  localparam int FRAC = WIDTH - 2;
  // Products carry 2*FRAC fraction bits; two guard bits keep sums exact.
  localparam int PW   = 2 * WIDTH + 2;

  // 4.0 at product scale, i.e. |z|^2 > 4 means |z| > 2
  localparam logic signed [PW-1:0] FOUR =
    {{(PW - 2*FRAC - 3){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};

  logic signed [PW-1:0] zr_x, zi_x, cr_x, ci_x;
  logic signed [PW-1:0] zr2, zi2, zrzi, sum_sq;
  logic signed [PW-1:0] nr, ni;

  assign zr_x = {{(PW-WIDTH){zr[WIDTH-1]}}, zr};
  assign zi_x = {{(PW-WIDTH){zi[WIDTH-1]}}, zi};
  assign cr_x = {{(PW-WIDTH){cr[WIDTH-1]}}, cr};
  assign ci_x = {{(PW-WIDTH){ci[WIDTH-1]}}, ci};

  assign zr2    = zr_x * zr_x;
  assign zi2    = zi_x * zi_x;
  assign zrzi   = zr_x * zi_x;
  assign sum_sq = zr2 + zi2;

  // Full-precision next z, rescaled back to FRAC fraction bits
  assign nr = ((zr2 - zi2) >>> FRAC) + cr_x;
  assign ni = ((zrzi <<< 1) >>> FRAC) + ci_x;

  assign out_zr = nr[WIDTH-1:0];
  assign out_zi = ni[WIDTH-1:0];

  assign size = (sum_sq > FOUR);

  // Next z does not fit when the bits above the sign bit disagree with it
  assign overflow = ((nr[PW-1:WIDTH-1] != '0) && (nr[PW-1:WIDTH-1] != '1)) ||
                    ((ni[PW-1:WIDTH-1] != '0) && (ni[PW-1:WIDTH-1] != '1));

endmodule

// File: rtl/mandelbrot_pixel_engine.sv
// Escape-time iteration engine for one Mandelbrot pixel per request.
// Latency: k+1 cycles from accept to out_valid, k = iterations completed.
// Accepts only in IDLE; result held in DONE until out_ready.
module mandelbrot_pixel_engine
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mandelbrot_pixel_engine_if.slave    bus
);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      zr_q, zi_q, cr_q, ci_q;
  logic [ITER_WIDTH-1:0] iter_q, max_lat_q, res_iter_q;
  logic                  res_esc_q;

  logic [WIDTH-1:0]      alu_zr, alu_zi;
  logic                  alu_size, alu_ovf;

  logic                  accept, step, finish, fin_esc;

  mandelbrot_alu #(.WIDTH(WIDTH)) u_alu (
    .zr       (zr_q),
    .zi       (zi_q),
    .cr       (cr_q),
    .ci       (ci_q),
    .out_zr   (alu_zr),
    .out_zi   (alu_zi),
    .size     (alu_size),
    .overflow (alu_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control; escape beats the limit in the same cycle
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    fin_esc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (alu_size || alu_ovf) begin
          finish  = 1'b1;
          fin_esc = 1'b1;
          state_d = ST_DONE;
        end else if (iter_q == max_lat_q) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // z, c, limit and counter registers; c and limit only change on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zr_q      <= '0;
      zi_q      <= '0;
      cr_q      <= '0;
      ci_q      <= '0;
      max_lat_q <= '0;
      iter_q    <= '0;
    end else if (accept) begin
      zr_q      <= '0;
      zi_q      <= '0;
      cr_q      <= bus.in_cr;
      ci_q      <= bus.in_ci;
      max_lat_q <= bus.max_iter;
      iter_q    <= '0;
    end else if (step) begin
      zr_q   <= alu_zr;
      zi_q   <= alu_zi;
      iter_q <= iter_q + 1'b1;
    end
  end

  // Result registers, written once when iteration stops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_iter_q <= '0;
      res_esc_q  <= 1'b0;
    end else if (finish) begin
      res_iter_q <= iter_q;
      res_esc_q  <= fin_esc;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.out_iter    = res_iter_q;
  assign bus.out_escaped = res_esc_q;

endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Directed bench for mandelbrot_pixel_engine at WIDTH=8 (1.0 = 64).
// Each task drives one scenario and compares against hand-computed values.
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_mandelbrot_pixel_engine;
  import mandelbrot_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mandelbrot_pixel_engine_if #(.WIDTH(8), .ITER_WIDTH(6)) bus ();

  mandelbrot_pixel_engine #(.WIDTH(8), .ITER_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pixel: accept, then count edges until out_valid; handshake if ordy.
  task automatic run_pixel(input logic [7:0] cr, input logic [7:0] ci,
                           input logic [5:0] mi, input logic ordy,
                           output logic [5:0] it, output logic esc,
                           output int lat);
    lat = -1;
    bus.in_cr     = cr;
    bus.in_ci     = ci;
    bus.max_iter  = mi;
    bus.out_ready = ordy;
    for (int w = 0; w < 20; w++) begin
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    it  = bus.out_iter;
    esc = bus.out_escaped;
    if (ordy && lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_iter !== 6'd0) begin n_bad++; $display("FAIL reset_out_iter got=%0d exp=0", bus.out_iter); end
    n_cmp++; if (bus.out_escaped !== 1'b0) begin n_bad++; $display("FAIL reset_out_escaped got=%b exp=0", bus.out_escaped); end
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_origin;
    logic [5:0] it; logic esc; int lat;
    run_pixel(8'd0, 8'd0, 6'd20, 1'b1, it, esc, lat);
    n_cmp++; if (it !== 6'd20) begin n_bad++; $display("FAIL origin_iter got=%0d exp=20", it); end
    n_cmp++; if (esc !== 1'b0) begin n_bad++; $display("FAIL origin_escaped got=%b exp=0", esc); end
    n_cmp++; if (lat != 21) begin n_bad++; $display("FAIL origin_latency got=%0d exp=21", lat); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL origin_idle_after got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_overflow_escape;
    logic [5:0] it; logic esc; int lat;
    run_pixel(8'd64, 8'd64, 6'd20, 1'b1, it, esc, lat);
    n_cmp++; if (it !== 6'd1) begin n_bad++; $display("FAIL ovf_iter got=%0d exp=1", it); end
    n_cmp++; if (esc !== 1'b1) begin n_bad++; $display("FAIL ovf_escaped got=%b exp=1", esc); end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL ovf_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_cycle_minus_one;
    logic [5:0] it; logic esc; int lat;
    run_pixel(8'hC0, 8'd0, 6'd10, 1'b1, it, esc, lat);
    n_cmp++; if (it !== 6'd10) begin n_bad++; $display("FAIL m1_iter got=%0d exp=10", it); end
    n_cmp++; if (esc !== 1'b0) begin n_bad++; $display("FAIL m1_escaped got=%b exp=0", esc); end
    n_cmp++; if (lat != 11) begin n_bad++; $display("FAIL m1_latency got=%0d exp=11", lat); end
  endtask

  task automatic test_limits;
    logic [5:0] it; logic esc; int lat;
    run_pixel(8'd64, 8'd64, 6'd0, 1'b1, it, esc, lat);
    n_cmp++; if (it !== 6'd0) begin n_bad++; $display("FAIL lim0_iter got=%0d exp=0", it); end
    n_cmp++; if (esc !== 1'b0) begin n_bad++; $display("FAIL lim0_escaped got=%b exp=0", esc); end
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL lim0_latency got=%0d exp=1", lat); end
    run_pixel(8'd64, 8'd64, 6'd1, 1'b1, it, esc, lat);
    n_cmp++; if (it !== 6'd1) begin n_bad++; $display("FAIL prio_iter got=%0d exp=1", it); end
    n_cmp++; if (esc !== 1'b1) begin n_bad++; $display("FAIL prio_escaped got=%b exp=1", esc); end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL prio_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_backpressure;
    logic [5:0] it; logic esc; int lat;
    run_pixel(8'd64, 8'd64, 6'd20, 1'b0, it, esc, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL bp_latency got=%0d exp=2", lat); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_cr    = 8'($urandom);
      bus.in_ci    = 8'($urandom);
      bus.max_iter = 6'($urandom);
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      n_cmp++; if (bus.out_iter !== 6'd1) begin n_bad++; $display("FAIL bp_out_iter[%0d] got=%0d exp=1", i, bus.out_iter); end
      n_cmp++; if (bus.out_escaped !== 1'b1) begin n_bad++; $display("FAIL bp_out_escaped[%0d] got=%b exp=1", i, bus.out_escaped); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_stay_idle got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_iter;
    logic [5:0] it; logic esc; int lat;
    bus.in_cr     = 8'd0;
    bus.in_ci     = 8'd0;
    bus.max_iter  = 6'd20;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b exp=0", bus.in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_iter !== 6'd0) begin n_bad++; $display("FAIL arst_out_iter got=%0d exp=0", bus.out_iter); end
    n_cmp++; if (bus.out_escaped !== 1'b0) begin n_bad++; $display("FAIL arst_out_escaped got=%b exp=0", bus.out_escaped); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pixel(8'd0, 8'd0, 6'd3, 1'b1, it, esc, lat);
    n_cmp++; if (it !== 6'd3) begin n_bad++; $display("FAIL post_rst_iter got=%0d exp=3", it); end
    n_cmp++; if (esc !== 1'b0) begin n_bad++; $display("FAIL post_rst_escaped got=%b exp=0", esc); end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL post_rst_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_cr     = '0;
    bus.in_ci     = '0;
    bus.max_iter  = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_origin();
    test_overflow_escape();
    test_cycle_minus_one();
    test_limits();
    test_backpressure();
    test_reset_mid_iter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_pixel_engine.md
# mandelbrot_pixel_engine

Sequential iteration engine that computes the escape-time iteration count for one Mandelbrot pixel. It accepts a point c = (cr, ci) through a valid/ready request port. It then repeatedly feeds z into the combinational `mandelbrot_alu` step, consuming the ALU's `out_zr`/`out_zi`/`size`/`overflow` results each cycle. It returns the iteration count through a valid/ready result port. It sits between the pixel-coordinate generator and the colour/output stage.

## Interface
- `WIDTH`, default 8: fixed-point width of cr, ci, zr, zi.
  - Format is 2.(WIDTH-2), two's complement; 1.0 = 1<<(WIDTH-2).
- `ITER_WIDTH`, default 6: width of the iteration counter and of `max_iter`.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: engine can accept a request; high only in IDLE.
- `in_cr`, input, WIDTH: real part of c.
- `in_ci`, input, WIDTH: imaginary part of c.
- `max_iter`, input, ITER_WIDTH: iteration limit; sampled together with c.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_iter`, output, ITER_WIDTH: number of z updates completed when the engine stopped.
- `out_escaped`, output, 1: 1 = diverged (size or overflow); 0 = hit `max_iter`.

## Operation
- State machine IDLE → ITER → DONE → IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch cr, ci, max_iter; zr←0, zi←0, iter←0; go to ITER.
- ITER, one ALU evaluation per cycle on the current (zr, zi). Priority order:
  1. `size` | `overflow` → out_escaped←1, out_iter←iter, go to DONE.
  2. Else iter == max_lat → out_escaped←0, out_iter←iter, go to DONE.
  3. Else zr←out_zr, zi←out_zi, iter←iter+1.
- Escape checking therefore takes priority over the limit in the same cycle.
- `size` is judged on the current z; `overflow` is judged on the next z, which is not committed.
- DONE:
  - `out_valid`=1; `out_iter`/`out_escaped` held stable until `out_ready`.
  - On `out_valid`&`out_ready` → IDLE.
- `in_valid` is ignored outside IDLE. Latched cr/ci/max_iter are unaffected by input changes during ITER/DONE.
- The iteration counter never wraps: it stops at max_iter ≤ 2^ITER_WIDTH-1.
- Arithmetic is entirely inside `mandelbrot_alu`; the engine only registers its WIDTH-bit outputs.

## Timing
- Reset (async assert, any state):
  - state=IDLE; zr=zi=0; iter=0.
  - `out_valid`=0, `out_iter`=0, `out_escaped`=0, `in_ready`=1.
  - A request or result in flight is discarded.
  - Deassertion is synchronised externally; the first edge after release may accept a request.
- Latency from the accept edge to `out_valid` high: k+1 cycles.
  - k = iterations performed (`out_iter`).
  - Cases are max_iter=0 → 1 cycle, and escape at iter 0 → 1 cycle.
- Throughput: k+3 cycles per pixel with `out_ready` held high (accept, k+1 ITER, DONE).
- `in_ready` and `out_valid` are decoded from registered state; no combinational path from `in_valid`/`out_ready` to them.

## Structure
- Shared package `mandelbrot_pkg`:
  - state encoding constants (IDLE/ITER/DONE);
  - fixed-point ONE constant `1<<(WIDTH-2)` used by benches.
- One sub-module, natural and reused as-is: `mandelbrot_alu #(.WIDTH(WIDTH))`, instantiated once.
- Engine RTL is the FSM, z/c/limit registers, counter and handshakes.

## Test plan
All cases use WIDTH=8, so 1.0=64.
- c=(0,0), max_iter=20, out_ready=1 → out_iter=20, out_escaped=0, out_valid 21 cycles after accept.
- c=(64,64), max_iter=20 → z1=(1,1); next zi=3 overflows → out_iter=1, out_escaped=1.
- c=(-64,0), max_iter=10 → z alternates -1/0, never escapes → out_iter=10, out_escaped=0.
- max_iter=0, c=(64,64) → out_iter=0, out_escaped=0; also escape-before-limit priority with max_iter=1 → out_iter=1, out_escaped=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and inputs → out_valid, out_iter and out_escaped stable, in_ready=0, no new request accepted; release → one handshake, then IDLE.
- Assert rst_n=0 mid-ITER → outputs go to their reset values immediately (async); after release a new request c=(0,0), max_iter=3 yields out_iter=3, out_escaped=0.
